z80_intack_master: RTL
======================

// Module: z80_intack_master
// PURPOSE
//  CPU-side initiator of the Z80 mode-2 interrupt protocol for the bridge's emulated Z80 bus.
//  Watches the daisy-chain INT_n, runs the M1+IORQ acknowledge cycle and captures the vector.
//  On request, issues a RETI opcode-fetch pair (ED,4D) so chained peripherals release IEO.
//  Sits between the bridge host logic and the shared M1_n/IORQ_n/RD_n/data bus.
// PARAMETERS
//  TDIV      1  clocks per Z80 T-state (1..15); every T-state below lasts TDIV clocks
//  ACK_WAIT  2  wait states inserted in the ack cycle (1..3)
// PORTS
//  CLK       in   1  system clock, all logic rising-edge
//  RESET     in   1  synchronous, active-high reset
//  INT_n     in   1  daisy-chain interrupt request, active low (async, synchronised inside)
//  ACK_EN    in   1  1 = acknowledge INT_n automatically; 0 = ignore INT_n
//  RETI_REQ  in   1  one-clock pulse: run RETI fetch sequence
//  DI        in   8  bus data in (vector during ack)
//  DO        out  8  bus data out (opcode during RETI fetches)
//  DO_EN     out  1  1 = DO drives bus
//  M1_n      out  1  Z80 M1 strobe
//  IORQ_n    out  1  Z80 IORQ strobe
//  RD_n      out  1  Z80 RD strobe
//  VECTOR    out  8  last captured vector
//  VECT_VLD  out  1  one-clock pulse: VECTOR updated
//  RETI_DONE out  1  one-clock pulse: RETI sequence finished
//  BUSY      out  1  1 = any bus cycle in progress
// BEHAVIOUR
//  Reset: M1_n=IORQ_n=RD_n=1, DO=8'h00, DO_EN=0, VECTOR=8'h00, pulses=0, BUSY=0, state IDLE,
//   RETI pending flag cleared; synchroniser flops set to 1. Reset mid-cycle: strobes high next clock.
//  INT_n passes a 2-flop synchroniser (INT_s); latency 2 clocks.
//  States: IDLE, ACK_T1, ACK_T2, ACK_TW(1..ACK_WAIT), ACK_T3, F_T1, F_T2, F_T3, F_T4.
//  IDLE priority: RETI pending > (ACK_EN & !INT_s) > stay. BUSY=1 in every state except IDLE.
//  Ack cycle: M1_n=0 from ACK_T1 to end of ACK_T3; IORQ_n=0 in last ACK_TW and ACK_T3;
//   RD_n stays 1. DI sampled on the final clock of ACK_T3 -> VECTOR; VECT_VLD pulses the
//   following clock (state back in IDLE). Ack total = (3+ACK_WAIT)*TDIV clocks.
//  RETI: two fetch cycles, opcode ED then 4D. Each: F_T1,F_T2 M1_n=RD_n=0; F_T3,F_T4 strobes
//   high (refresh, no RFSH modelled). DO=opcode, DO_EN=1 from F_T1 through F_T3 so the
//   M1_n|RD_n rising edge sees stable data; DO_EN=0 in F_T4. 8*TDIV clocks total;
//   RETI_DONE pulses the clock after second F_T4.
//  RETI_REQ in any state sets pending (1-deep); extra requests while pending are dropped.
//   Pending cleared on entering first F_T1.
//  INT_n changes during a cycle ignored; re-evaluated only in IDLE. If INT_s still low after
//   an ack (peripheral not yet cleared), a new ack starts -- host must drop ACK_EN if unwanted.
//  Never M1_n & IORQ_n & RD_n all low simultaneously; IORQ_n never low outside ack cycle.
//  T-state counter: 4-bit, reloads at TDIV-1 on each state entry, advances state at 0.
// CONFIGURATION
//  INTACK_VECT_CHECK_EN defined: adds output VECT_ERR (1 bit, reset 0); set with VECT_VLD
//   when captured vector bit0=1 (IM2 requires even vector), held until next VECT_VLD or reset.
//   VECTOR still updated. Undefined: port absent, no check logic.
// TESTING
//  T1 reset mid-ack (TDIV=1, in ACK_TW) -> next clock M1_n=IORQ_n=1, BUSY=0, VECTOR=00.
//  T2 ACK_EN=1, INT_n low, DI=8'h3A at T3 -> M1_n low 5 clk, IORQ_n low 2 clk, VECTOR=3A, VECT_VLD 1 clk.
//  T3 RETI_REQ pulse -> bus shows DO=ED then 4D at each M1_n|RD_n rise, RETI_DONE after 8 clk.
//  T4 RETI_REQ and INT_n low same clock in IDLE -> RETI runs first, then ack; extra RETI_REQ dropped.
//  T5 TDIV=3, ACK_WAIT=1 -> ack lasts 12 clk, RETI 24 clk; strobe widths scale by 3.
//  T6 INTACK_VECT_CHECK_EN, DI=8'h41 -> VECT_ERR=1; next ack DI=8'h40 -> VECT_ERR=0.

Source files
------------

// File: rtl/z80_intack_master.sv
// z80_intack_master: CPU-side initiator of the Z80 mode-2 interrupt acknowledge
// and RETI (ED,4D) opcode-fetch sequences on the bridge's emulated Z80 bus.
// Optional feature macro: INTACK_VECT_CHECK_EN adds VECT_ERR, flagging odd vectors.
module z80_intack_master #(
    parameter int TDIV     = 1,   // clocks per T-state (1..15)
    parameter int ACK_WAIT = 2    // wait states in the ack cycle (1..3)
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       INT_n,
    input  logic       ACK_EN,
    input  logic       RETI_REQ,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    output logic       DO_EN,
    output logic       M1_n,
    output logic       IORQ_n,
    output logic       RD_n,
    output logic [7:0] VECTOR,
    output logic       VECT_VLD,
    output logic       RETI_DONE,
    output logic       BUSY
`ifdef INTACK_VECT_CHECK_EN
    ,
    output logic       VECT_ERR
`endif
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACK_T1,
        S_ACK_T2,
        S_ACK_TW,
        S_ACK_T3,
        S_F_T1,
        S_F_T2,
        S_F_T3,
        S_F_T4
    } state_t;

    localparam logic [3:0] T_RELOAD = 4'(TDIV - 1);
    localparam logic [1:0] W_LAST   = 2'(ACK_WAIT - 1);

    state_t     state_q, state_d;
    logic [3:0] tcnt_q, tcnt_d;        // clocks left in the current T-state
    logic [1:0] wait_q, wait_d;        // index of the current ack wait state
    logic       fetch2_q, fetch2_d;    // 0 = fetching ED, 1 = fetching 4D
    logic       pend_q, pend_d;        // RETI request waiting for IDLE
    logic       int_s1_q, int_s2_q;    // INT_n synchroniser
    logic [7:0] vector_q, vector_d;
    logic       vect_vld_q, vect_vld_d;
    logic       reti_done_q, reti_done_d;
    logic       vect_err_q, vect_err_d;
    logic       t_end;

    assign t_end = (tcnt_q == 4'd0);

    // State, timing and capture registers; reset parks the bus with strobes released.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            tcnt_q      <= T_RELOAD;
            wait_q      <= 2'd0;
            fetch2_q    <= 1'b0;
            pend_q      <= 1'b0;
            int_s1_q    <= 1'b1;
            int_s2_q    <= 1'b1;
            vector_q    <= 8'h00;
            vect_vld_q  <= 1'b0;
            reti_done_q <= 1'b0;
            vect_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            wait_q      <= wait_d;
            fetch2_q    <= fetch2_d;
            pend_q      <= pend_d;
            int_s1_q    <= INT_n;
            int_s2_q    <= int_s1_q;
            vector_q    <= vector_d;
            vect_vld_q  <= vect_vld_d;
            reti_done_q <= reti_done_d;
            vect_err_q  <= vect_err_d;
        end
    end

    // Next-state logic: IDLE arbitration, T-state sequencing, vector capture and pulses.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        fetch2_d    = fetch2_q;
        pend_d      = pend_q;
        vector_d    = vector_q;
        vect_vld_d  = 1'b0;
        reti_done_d = 1'b0;
        vect_err_d  = vect_err_q;

        // A request arriving while one is already pending is simply absorbed.
        if (RETI_REQ) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    state_d  = S_F_T1;
                    fetch2_d = 1'b0;
                    pend_d   = 1'b0;
                end else if (ACK_EN && !int_s2_q) begin
                    state_d = S_ACK_T1;
                end
            end
            S_ACK_T1: if (t_end) state_d = S_ACK_T2;
            S_ACK_T2: begin
                if (t_end) begin
                    state_d = S_ACK_TW;
                    wait_d  = 2'd0;
                end
            end
            S_ACK_TW: begin
                if (t_end) begin
                    if (wait_q == W_LAST) begin
                        state_d = S_ACK_T3;
                    end else begin
                        wait_d = wait_q + 2'd1;
                    end
                end
            end
            S_ACK_T3: begin
                if (t_end) begin
                    state_d    = S_IDLE;
                    vector_d   = DI;
                    vect_vld_d = 1'b1;
                    vect_err_d = DI[0];
                end
            end
            S_F_T1: if (t_end) state_d = S_F_T2;
            S_F_T2: if (t_end) state_d = S_F_T3;
            S_F_T3: if (t_end) state_d = S_F_T4;
            S_F_T4: begin
                if (t_end) begin
                    if (fetch2_q) begin
                        state_d     = S_IDLE;
                        reti_done_d = 1'b1;
                    end else begin
                        state_d  = S_F_T1;
                        fetch2_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every T-state (including each repeated wait state) starts with a full count.
        if (state_q == S_IDLE || t_end) begin
            tcnt_d = T_RELOAD;
        end else begin
            tcnt_d = tcnt_q - 4'd1;
        end
    end

    // Bus strobes decoded from the registered state so they never glitch on DI or requests.
    always_comb begin
        M1_n   = 1'b1;
        IORQ_n = 1'b1;
        RD_n   = 1'b1;
        DO_EN  = 1'b0;
        unique case (state_q)
            S_ACK_T1, S_ACK_T2: M1_n = 1'b0;
            S_ACK_TW: begin
                M1_n   = 1'b0;
                IORQ_n = (wait_q == W_LAST) ? 1'b0 : 1'b1;
            end
            S_ACK_T3: begin
                M1_n   = 1'b0;
                IORQ_n = 1'b0;
            end
            S_F_T1, S_F_T2: begin
                M1_n  = 1'b0;
                RD_n  = 1'b0;
                DO_EN = 1'b1;
            end
            // Opcode held through T3 so the rising M1_n/RD_n edge sees stable data.
            S_F_T3: DO_EN = 1'b1;
            default: ;
        endcase
        DO = DO_EN ? (fetch2_q ? 8'h4D : 8'hED) : 8'h00;
    end

    assign BUSY      = (state_q != S_IDLE);
    assign VECTOR    = vector_q;
    assign VECT_VLD  = vect_vld_q;
    assign RETI_DONE = reti_done_q;

`ifdef INTACK_VECT_CHECK_EN
    assign VECT_ERR = vect_err_q;
`else
    logic unused_vect_err;
    assign unused_vect_err = vect_err_q;
`endif

endmodule
